router_pkt_reader: RTL and testbench

// - Destination-side consumer for one router output port; the read end of the per-port output FIFO.
// - Issues read_enb while the port has data, parses header {len[7:2],addr[1:0]}, streams payload, checks parity.
// - Flags done, error and abort per packet.
// - One instance per port (3 total); used at the chip boundary and as the standard bench sink.

---
 rtl/router_pkg.sv | 22 ++
 rtl/router_pkt_reader_if.sv | 10 +
 rtl/router_rd_pacer.sv | 35 +++
 rtl/router_pkt_reader.sv | 185 ++++++++++++++++++
 tb/tb_router_pkt_reader.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port reader: FSM encoding and
// header field layout {len[7:2], addr[1:0]}.
package router_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PLD  = 3'd2,
    ST_PAR  = 3'd3,
    ST_DONE = 3'd4
  } rd_state_e;

  localparam int HDR_LEN_MSB = 7;
  localparam int HDR_LEN_LSB = 2;
  localparam int HDR_ADDR_W  = 2;
  localparam int MAX_LEN     = 63;

  // len field width and the request counter width (len + parity byte)
  localparam int LEN_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int REQ_W = LEN_W + 1;

endpackage

// File: rtl/router_pkt_reader_if.sv
// FIFO read-side bundle between a router output-port FIFO and its reader.
// master: the reader (issues read_enb); slave: the FIFO.
interface router_pkt_reader_if;
  logic       valid_out;
  logic [7:0] data_out;
  logic       read_enb;

  modport master (input valid_out, input data_out, output read_enb);
  modport slave  (output valid_out, output data_out, input read_enb);
endinterface

// File: rtl/router_rd_pacer.sv
// Read pacer: after every read request, holds off further requests for
// RD_GAP cycles. gap_ok_o is high when a new request may be issued.
module router_rd_pacer #(
  parameter int RD_GAP = 0,
  parameter int GAP_W  = 5
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr_i,
  input  logic rd_enb_i,
  output logic gap_ok_o
);

  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  // Reload on a request, otherwise count down to zero; soft clear wins.
  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (clr_i)
      gap_cnt_d = '0;
    else if (rd_enb_i)
      gap_cnt_d = GAP_W'(RD_GAP);
    else if (gap_cnt_q != '0)
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
  end

  // Gap counter register.
  always_ff @(posedge clock) begin
    if (!resetn) gap_cnt_q <= '0;
    else         gap_cnt_q <= gap_cnt_d;
  end

  assign gap_ok_o = (gap_cnt_q == '0);

endmodule

// File: rtl/router_pkt_reader.sv
// Destination-side packet reader for one router output port.
// Pops the port FIFO, parses the header, streams payload, checks parity,
// and flags done / parity error / abort per packet.
// Optional build macro ROUTER_RD_STATS_EN adds saturating pkt_cnt/err_cnt.
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int RD_GAP = 0,
  parameter int GAP_W  = 5
) (
  input  logic                  clock,
  input  logic                  resetn,
  router_pkt_reader_if.master   fifo,
  input  logic                  soft_reset,
  output logic                  payload_valid,
  output logic [7:0]            payload_data,
  output logic                  pkt_done,
  output logic [HDR_ADDR_W-1:0] pkt_addr,
  output logic [LEN_W-1:0]      pkt_len,
  output logic                  parity_err,
  output logic                  pkt_abort,
  output logic                  busy
`ifdef ROUTER_RD_STATS_EN
  ,
  output logic [15:0]           pkt_cnt,
  output logic [15:0]           err_cnt
`endif
);

  rd_state_e             state_q, state_d;
  logic [REQ_W-1:0]      req_left_q, req_left_d;
  logic [LEN_W-1:0]      pld_left_q, pld_left_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [7:0]            acc_q, acc_d;
  logic                  payload_valid_q, payload_valid_d;
  logic [7:0]            payload_data_q, payload_data_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  parity_err_q, parity_err_d;
  logic                  pkt_abort_q, pkt_abort_d;
  logic [HDR_ADDR_W-1:0] pkt_addr_q, pkt_addr_d;
  logic [LEN_W-1:0]      pkt_len_q, pkt_len_d;
  logic                  gap_ok;
  logic                  rd_enb;
  logic [LEN_W-1:0]      hdr_len;

  router_rd_pacer #(.RD_GAP(RD_GAP), .GAP_W(GAP_W)) u_pacer (
    .clock    (clock),
    .resetn   (resetn),
    .clr_i    (soft_reset),
    .rd_enb_i (rd_enb),
    .gap_ok_o (gap_ok)
  );

  // req_left bounds reads to the current packet, so the next header is
  // never popped before DONE; DONE itself also blocks reads.
  assign rd_enb = fifo.valid_out & (req_left_q != '0) & gap_ok &
                  ~soft_reset & (state_q != ST_DONE);
  assign fifo.read_enb = rd_enb;
  assign hdr_len = fifo.data_out[HDR_LEN_MSB:HDR_LEN_LSB];

  // Next-state: FSM, request/payload counters, parity and output pulses.
  always_comb begin
    state_d         = state_q;
    req_left_d      = req_left_q;
    pld_left_d      = pld_left_q;
    rd_pend_d       = rd_enb;
    acc_d           = acc_q;
    payload_valid_d = 1'b0;
    payload_data_d  = payload_data_q;
    pkt_done_d      = 1'b0;
    parity_err_d    = parity_err_q;
    pkt_abort_d     = 1'b0;
    pkt_addr_d      = pkt_addr_q;
    pkt_len_d       = pkt_len_q;

    if (rd_enb) req_left_d = req_left_q - REQ_W'(1);

    if (soft_reset) begin
      // Drop the packet; a byte still in flight from the FIFO is discarded.
      pkt_abort_d = (state_q != ST_IDLE);
      state_d     = ST_IDLE;
      rd_pend_d   = 1'b0;
      req_left_d  = REQ_W'(1);
      pld_left_d  = '0;
      acc_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (rd_enb) state_d = ST_HDR;
        ST_HDR: begin
          if (rd_pend_q) begin
            pkt_len_d  = hdr_len;
            pkt_addr_d = fifo.data_out[HDR_ADDR_W-1:0];
            acc_d      = acc_q ^ fifo.data_out;
            req_left_d = REQ_W'(hdr_len) + REQ_W'(1);
            pld_left_d = hdr_len;
            state_d    = (hdr_len != '0) ? ST_PLD : ST_PAR;
          end
        end
        ST_PLD: begin
          if (rd_pend_q) begin
            payload_valid_d = 1'b1;
            payload_data_d  = fifo.data_out;
            acc_d           = acc_q ^ fifo.data_out;
            pld_left_d      = pld_left_q - LEN_W'(1);
            if (pld_left_q == LEN_W'(1)) state_d = ST_PAR;
          end
        end
        ST_PAR: begin
          if (rd_pend_q) begin
            pkt_done_d   = 1'b1;
            parity_err_d = (fifo.data_out != acc_q);
            state_d      = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d    = ST_IDLE;
          req_left_d = REQ_W'(1);
          acc_d      = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      req_left_q      <= REQ_W'(1);
      pld_left_q      <= '0;
      rd_pend_q       <= 1'b0;
      acc_q           <= '0;
      payload_valid_q <= 1'b0;
      payload_data_q  <= '0;
      pkt_done_q      <= 1'b0;
      parity_err_q    <= 1'b0;
      pkt_abort_q     <= 1'b0;
      pkt_addr_q      <= '0;
      pkt_len_q       <= '0;
    end else begin
      state_q         <= state_d;
      req_left_q      <= req_left_d;
      pld_left_q      <= pld_left_d;
      rd_pend_q       <= rd_pend_d;
      acc_q           <= acc_d;
      payload_valid_q <= payload_valid_d;
      payload_data_q  <= payload_data_d;
      pkt_done_q      <= pkt_done_d;
      parity_err_q    <= parity_err_d;
      pkt_abort_q     <= pkt_abort_d;
      pkt_addr_q      <= pkt_addr_d;
      pkt_len_q       <= pkt_len_d;
    end
  end

  assign payload_valid = payload_valid_q;
  assign payload_data  = payload_data_q;
  assign pkt_done      = pkt_done_q;
  assign parity_err    = parity_err_q;
  assign pkt_abort     = pkt_abort_q;
  assign pkt_addr      = pkt_addr_q;
  assign pkt_len       = pkt_len_q;
  assign busy          = (state_q != ST_IDLE);

`ifdef ROUTER_RD_STATS_EN
  logic [15:0] pkt_cnt_q, err_cnt_q;

  // Saturating statistics; only a hard reset clears them.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pkt_done_q && pkt_cnt_q != 16'hFFFF)
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (((pkt_done_q && parity_err_q) || pkt_abort_q) && err_cnt_q != 16'hFFFF)
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_pkt_reader.sv
// Directed bench for router_pkt_reader: two instances (RD_GAP=0 and 3),
// each fed by a simple FIFO model with registered read data.
module tb_router_pkt_reader;

  logic clock = 1'b0;
  logic resetn;
  logic soft0, soft1;
  always #5 clock = ~clock;

  router_pkt_reader_if if0 ();
  router_pkt_reader_if if1 ();

  logic       pv0, done0, perr0, abort0, busy0;
  logic [7:0] pd0;
  logic [1:0] addr0;
  logic [5:0] len0;
  logic       pv1, done1, perr1, abort1, busy1;
  logic [7:0] pd1;
  logic [1:0] addr1;
  logic [5:0] len1;
`ifdef ROUTER_RD_STATS_EN
  logic [15:0] pc0, ec0, pc1, ec1;
`endif

  router_pkt_reader #(.RD_GAP(0), .GAP_W(5)) dut (
    .clock(clock), .resetn(resetn), .fifo(if0.master), .soft_reset(soft0),
    .payload_valid(pv0), .payload_data(pd0), .pkt_done(done0),
    .pkt_addr(addr0), .pkt_len(len0), .parity_err(perr0),
    .pkt_abort(abort0), .busy(busy0)
`ifdef ROUTER_RD_STATS_EN
    , .pkt_cnt(pc0), .err_cnt(ec0)
`endif
  );

  router_pkt_reader #(.RD_GAP(3), .GAP_W(5)) dut_gap (
    .clock(clock), .resetn(resetn), .fifo(if1.master), .soft_reset(soft1),
    .payload_valid(pv1), .payload_data(pd1), .pkt_done(done1),
    .pkt_addr(addr1), .pkt_len(len1), .parity_err(perr1),
    .pkt_abort(abort1), .busy(busy1)
`ifdef ROUTER_RD_STATS_EN
    , .pkt_cnt(pc1), .err_cnt(ec1)
`endif
  );

  // FIFO models: data_out registered on read_enb; flushed on reset/soft reset.
  logic [7:0] f0_mem [0:255];
  logic [7:0] f1_mem [0:255];
  int f0_wr = 0, f0_rd = 0, f1_wr = 0, f1_rd = 0;
  assign if0.valid_out = (f0_wr != f0_rd);
  assign if1.valid_out = (f1_wr != f1_rd);

  always @(posedge clock) begin
    if (!resetn || soft0) f0_rd <= f0_wr;
    else if (if0.read_enb) begin
      if0.data_out <= f0_mem[f0_rd];
      f0_rd <= f0_rd + 1;
    end
  end

  always @(posedge clock) begin
    if (!resetn || soft1) f1_rd <= f1_wr;
    else if (if1.read_enb) begin
      if1.data_out <= f1_mem[f1_rd];
      f1_rd <= f1_rd + 1;
    end
  end

  // Event monitors (pre-edge values).
  int cyc = 0, rd_cnt = 0, rd_in_done = 0, pv_cnt = 0, n_rt1 = 0;
  logic [7:0] pv_mem [0:255];
  int rt1 [0:15];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (if0.read_enb) rd_cnt <= rd_cnt + 1;
    if (if0.read_enb && done0) rd_in_done <= rd_in_done + 1;
    if (pv0) begin
      pv_mem[pv_cnt] <= pd0;
      pv_cnt <= pv_cnt + 1;
    end
    if (if1.read_enb && n_rt1 < 16) begin
      rt1[n_rt1] <= cyc;
      n_rt1 <= n_rt1 + 1;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push0(input logic [7:0] b);
    f0_mem[f0_wr] = b;
    f0_wr = f0_wr + 1;
  endtask

  task automatic push1(input logic [7:0] b);
    f1_mem[f1_wr] = b;
    f1_wr = f1_wr + 1;
  endtask

  task automatic wait_done0(input string tag, input int lim);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(negedge clock);
      if (done0) seen = 1'b1;
    end
    check(tag, seen, 1'b1);
  endtask

  int rd_base, pv_base;
  bit seen_p2;

  initial begin
    resetn = 1'b0; soft0 = 1'b0; soft1 = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy0, 1'b0);
    check("rst_read_enb", if0.read_enb, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_len", len0, 6'd0);
    check("rst_pv", pv0, 1'b0);
    check("rst_abort", abort0, 1'b0);
    resetn = 1'b1;
    @(negedge clock);

    // Good packet: len 3, addr 1
    rd_base = rd_cnt; pv_base = pv_cnt;
    push0(8'h0D); push0(8'h11); push0(8'h22); push0(8'h33); push0(8'h0D);
    wait_done0("good_done_seen", 30);
    check("good_perr", perr0, 1'b0);
    check("good_len", len0, 6'd3);
    check("good_addr", addr0, 2'd1);
    check("good_pv_cnt", pv_cnt - pv_base, 3);
    check("good_pv0", pv_mem[pv_base], 8'h11);
    check("good_pv1", pv_mem[pv_base+1], 8'h22);
    check("good_pv2", pv_mem[pv_base+2], 8'h33);
    check("good_reads", rd_cnt - rd_base, 5);
    @(negedge clock);
    check("good_done_pulse", done0, 1'b0);
    check("good_idle", busy0, 1'b0);

    // Bad parity
    push0(8'h0D); push0(8'h11); push0(8'h22); push0(8'h33); push0(8'h0C);
    wait_done0("bad_done_seen", 30);
    check("bad_perr", perr0, 1'b1);
    @(negedge clock);
`ifdef ROUTER_RD_STATS_EN
    check("stat_pkt_bad", pc0, 16'd2);
    check("stat_err_bad", ec0, 16'd1);
`endif

    // len = 0: header and parity only
    rd_base = rd_cnt; pv_base = pv_cnt;
    push0(8'h02); push0(8'h02);
    wait_done0("len0_done_seen", 20);
    check("len0_perr", perr0, 1'b0);
    check("len0_len", len0, 6'd0);
    check("len0_addr", addr0, 2'd2);
    check("len0_pv_cnt", pv_cnt - pv_base, 0);
    check("len0_reads", rd_cnt - rd_base, 2);
    @(negedge clock);

    // Back-to-back packets
    rd_base = rd_cnt;
    push0(8'h0D); push0(8'h11); push0(8'h22); push0(8'h33); push0(8'h0D);
    push0(8'h0B); push0(8'hAA); push0(8'h55); push0(8'hF4);
    wait_done0("b2b_done1_seen", 30);
    check("b2b_reads_at_done1", rd_cnt - rd_base, 5);
    check("b2b_perr1", perr0, 1'b0);
    wait_done0("b2b_done2_seen", 30);
    check("b2b_perr2", perr0, 1'b0);
    check("b2b_len2", len0, 6'd2);
    check("b2b_addr2", addr0, 2'd3);
    check("b2b_reads_total", rd_cnt - rd_base, 9);
    check("read_in_done", rd_in_done, 0);
    @(negedge clock);

    // Gap timing on the RD_GAP=3 instance
    push1(8'h14); push1(8'h01); push1(8'h02); push1(8'h03);
    push1(8'h04); push1(8'h05); push1(8'h15);
    begin
      bit seen1;
      seen1 = 1'b0;
      for (int i = 0; i < 80 && !seen1; i++) begin
        @(negedge clock);
        if (done1) seen1 = 1'b1;
      end
      check("gap_done_seen", seen1, 1'b1);
      check("gap_perr", perr1, 1'b0);
      check("gap_len", len1, 6'd5);
    end
    check("gap_reads", n_rt1, 7);
    for (int i = 1; i < 7; i++) check($sformatf("gap_%0d", i), rt1[i] - rt1[i-1], 4);

    // Abort after 2nd payload of a len-5 packet
    rd_base = rd_cnt;
    push0(8'h15); push0(8'h01); push0(8'h02); push0(8'h03);
    push0(8'h04); push0(8'h05); push0(8'h55);
    seen_p2 = 1'b0;
    for (int i = 0; i < 20 && !seen_p2; i++) begin
      @(negedge clock);
      if (pv0 && pd0 == 8'h02) seen_p2 = 1'b1;
    end
    check("abort_p2_seen", seen_p2, 1'b1);
    soft0 = 1'b1;
    #1;
    check("abort_valid_out", if0.valid_out, 1'b1);
    check("abort_read_forced0", if0.read_enb, 1'b0);
    @(negedge clock);
    check("abort_pulse", abort0, 1'b1);
    check("abort_busy", busy0, 1'b0);
    check("abort_pv_dropped", pv0, 1'b0);
    check("abort_done", done0, 1'b0);
    check("abort_reads", rd_cnt - rd_base, 4);
    check("abort_len_held", len0, 6'd5);
    check("abort_addr_held", addr0, 2'd1);
    soft0 = 1'b0;
    @(negedge clock);
    check("abort_pulse_end", abort0, 1'b0);

    // Packet after abort: len 1, addr 2
    push0(8'h06); push0(8'h77); push0(8'h71);
    wait_done0("post_abort_done_seen", 20);
    check("post_abort_perr", perr0, 1'b0);
    check("post_abort_len", len0, 6'd1);
    check("post_abort_addr", addr0, 2'd2);
    @(negedge clock);
`ifdef ROUTER_RD_STATS_EN
    check("stat_pkt_final", pc0, 16'd6);
    check("stat_err_final", ec0, 16'd2);
`endif

    // Hard reset mid-packet: full clear, no abort pulse
    push0(8'h0D); push0(8'h11); push0(8'h22); push0(8'h33); push0(8'h0D);
    repeat (3) @(negedge clock);
    check("mid_busy_before", busy0, 1'b1);
    resetn = 1'b0;
    @(negedge clock);
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_abort", abort0, 1'b0);
    check("mid_rst_len", len0, 6'd0);
    check("mid_rst_pv", pv0, 1'b0);
    resetn = 1'b1;
    @(negedge clock);
    check("mid_rst_abort_after", abort0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
